// File: rtl/pu_riscv_rf_access_ctrl.sv
// Register-file port arbiter: post-reset zero-clear of x1..xN, pipeline pass-through,
// and serialised debug-unit register reads/writes while the core is stalled.
`timescale 1ns/1ps
module pu_riscv_rf_access_ctrl #(
    parameter int XLEN    = 64,
    parameter int AR_BITS = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [AR_BITS-1:0] pl_src1,
    input  logic [AR_BITS-1:0] pl_dst,
    input  logic [XLEN-1:0]    pl_dstv,
    input  logic               pl_we,
    output logic               rf_busy,
    output logic [AR_BITS-1:0] rf_src1,
    input  logic [XLEN-1:0]    rf_srcv1,
    output logic [AR_BITS-1:0] rf_dst,
    output logic [XLEN-1:0]    rf_dstv,
    output logic               rf_we,
    input  logic               du_stall,
    input  logic               du_req,
    input  logic               du_we,
    input  logic [AR_BITS-1:0] du_addr,
    input  logic [XLEN-1:0]    du_wdata,
    output logic [XLEN-1:0]    du_rdata,
    output logic               du_ack
);

    typedef enum logic [2:0] {CLEAR, RUN, DU_WR, DU_RD, DU_RDATA} state_t;

    localparam logic [AR_BITS-1:0] LAST_REG = '1;
    localparam logic [AR_BITS-1:0] FIRST_REG = AR_BITS'(1);

    state_t             state_q, state_d;
    logic [AR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic [AR_BITS-1:0] cap_addr_q, cap_addr_d;
    logic [XLEN-1:0]    cap_data_q, cap_data_d;
    logic [XLEN-1:0]    du_rdata_q, du_rdata_d;
    logic               du_ack_q, du_ack_d;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        du_rdata_d = du_rdata_q;
        du_ack_d   = 1'b0;
        rf_busy    = 1'b1;
        rf_src1    = pl_src1;
        rf_dst     = '0;
        rf_dstv    = '0;
        rf_we      = 1'b0;

        case (state_q)
            CLEAR: begin
                rf_we  = 1'b1;
                rf_dst = clr_cnt_q;
                if (clr_cnt_q == LAST_REG) begin
                    clr_cnt_d = FIRST_REG;
                    state_d   = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + AR_BITS'(1);
                end
            end
            RUN: begin
                rf_busy = 1'b0;
                rf_dst  = pl_dst;
                rf_dstv = pl_dstv;
                rf_we   = pl_we & (pl_dst != '0);
                // A pending pipeline write keeps the port, so debug waits for a quiet cycle.
                if (du_req && du_stall && !pl_we) begin
                    cap_addr_d = du_addr;
                    cap_data_d = du_wdata;
                    state_d    = du_we ? DU_WR : DU_RD;
                end
            end
            DU_WR: begin
                if (pl_we) begin
                    rf_dst  = pl_dst;
                    rf_dstv = pl_dstv;
                    rf_we   = (pl_dst != '0);
                end else begin
                    rf_dst   = cap_addr_q;
                    rf_dstv  = cap_data_q;
                    rf_we    = (cap_addr_q != '0);
                    du_ack_d = 1'b1;
                    state_d  = RUN;
                end
            end
            DU_RD: begin
                rf_src1 = cap_addr_q;
                state_d = DU_RDATA;
            end
            DU_RDATA: begin
                rf_src1    = cap_addr_q;
                du_rdata_d = (cap_addr_q == '0) ? '0 : rf_srcv1;
                du_ack_d   = 1'b1;
                state_d    = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= FIRST_REG;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            du_rdata_q <= '0;
            du_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            du_rdata_q <= du_rdata_d;
            du_ack_q   <= du_ack_d;
        end
    end

    assign du_rdata = du_rdata_q;
    assign du_ack   = du_ack_q;

endmodule

// File: tb/tb_pu_riscv_rf_access_ctrl.sv
// Bench for pu_riscv_rf_access_ctrl: register-file model, vector table for pass-through,
// directed corner sequences and randomized debug/pipeline traffic against an expected register image.
`timescale 1ns/1ps
module tb_pu_riscv_rf_access_ctrl;

    localparam int XLEN = 64;
    localparam int AR   = 5;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic [AR-1:0]   pl_src1, pl_dst, rf_src1, rf_dst, du_addr;
    logic [XLEN-1:0] pl_dstv, rf_srcv1, rf_dstv, du_wdata, du_rdata;
    logic            pl_we, rf_busy, rf_we, du_stall, du_req, du_we, du_ack;
    logic            scramble;

    pu_riscv_rf_access_ctrl #(.XLEN(XLEN), .AR_BITS(AR)) dut (
        .clk(clk), .rstn(rstn),
        .pl_src1(pl_src1), .pl_dst(pl_dst), .pl_dstv(pl_dstv), .pl_we(pl_we),
        .rf_busy(rf_busy), .rf_src1(rf_src1), .rf_srcv1(rf_srcv1),
        .rf_dst(rf_dst), .rf_dstv(rf_dstv), .rf_we(rf_we),
        .du_stall(du_stall), .du_req(du_req), .du_we(du_we),
        .du_addr(du_addr), .du_wdata(du_wdata), .du_rdata(du_rdata), .du_ack(du_ack)
    );

    always #5 clk = ~clk;

    // Register file model; x0 deliberately holds junk so the read-side zero mask is exercised.
    logic [XLEN-1:0] rf_mem [0:NREG-1];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= 64'hBAD0_0000_0000_0000 + 64'(i);
        end else if (rf_we) begin
            rf_mem[rf_dst] <= rf_dstv;
        end
        rf_srcv1 <= rf_mem[rf_src1];
    end

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] exp_regs [0:NREG-1];
    logic [XLEN-1:0] last_rd;

    typedef struct {
        logic [AR-1:0]   src1;
        logic [AR-1:0]   dst;
        logic [XLEN-1:0] dstv;
        logic            we;
        logic            exp_we;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
        last_rd = '0;
    endtask

    // Entered at posedge+1 with rstn just released; leaves at the negedge of the first RUN cycle.
    task automatic check_clear();
        for (int i = 1; i < NREG; i++) begin
            @(negedge clk);
            chk("clr_we", 64'(rf_we), 64'(1));
            chk("clr_dst", 64'(rf_dst), 64'(i));
            chk("clr_dstv", rf_dstv, 64'(0));
            chk("clr_busy", 64'(rf_busy), 64'(1));
            chk("clr_ack", 64'(du_ack), 64'(0));
            tick();
        end
        @(negedge clk);
        chk("clr_done_busy", 64'(rf_busy), 64'(0));
        $display("clear sequence x1..x%0d observed", NREG - 1);
    endtask

    task automatic pl_write(input logic [AR-1:0] src1, input logic [AR-1:0] dst,
                            input logic [XLEN-1:0] data);
        pl_src1 = src1; pl_dst = dst; pl_dstv = data; pl_we = 1'b1;
        @(negedge clk);
        chk("pl_we", 64'(rf_we), 64'(dst != 0));
        chk("pl_dst", 64'(rf_dst), 64'(dst));
        chk("pl_dstv", rf_dstv, data);
        chk("pl_src1", 64'(rf_src1), 64'(src1));
        chk("pl_busy", 64'(rf_busy), 64'(0));
        tick();
        pl_we = 1'b0;
        if (dst != 0) exp_regs[dst] = data;
        $display("pl write x%0d=%h", dst, data);
    endtask

    // Debug access: request held with stall low for stall_delay cycles, then admitted.
    task automatic du_access(input logic we, input logic [AR-1:0] addr,
                             input logic [XLEN-1:0] data, input int stall_delay);
        int cnt;
        logic [XLEN-1:0] exp_rd;
        du_req = 1'b1; du_we = we; du_addr = addr; du_wdata = data;
        pl_we = 1'b0; du_stall = 1'b0;
        for (int k = 0; k < stall_delay; k++) begin
            @(negedge clk);
            chk("nostall_busy", 64'(rf_busy), 64'(0));
            chk("nostall_ack", 64'(du_ack), 64'(0));
            tick();
        end
        du_stall = 1'b1;
        tick();
        du_stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("acc_busy", 64'(rf_busy), 64'(1));
        chk("acc_ack", 64'(du_ack), 64'(0));
        if (we) begin
            chk("dw_we", 64'(rf_we), 64'(addr != 0));
            chk("dw_dst", 64'(rf_dst), 64'(addr));
            chk("dw_dstv", rf_dstv, data);
        end else begin
            chk("dr_src1", 64'(rf_src1), 64'(addr));
            chk("dr_we", 64'(rf_we), 64'(0));
        end
        cnt = 1;
        do begin
            tick();
            cnt++;
        end while (du_ack !== 1'b1 && cnt < 8);
        chk("ack_seen", 64'(du_ack), 64'(1));
        chk("latency", 64'(cnt), we ? 64'(2) : 64'(3));
        if (we) begin
            chk("rdata_hold", du_rdata, last_rd);
            if (addr != 0) exp_regs[addr] = data;
        end else begin
            exp_rd = (addr == 0) ? '0 : exp_regs[addr];
            chk("rdata", du_rdata, exp_rd);
            last_rd = exp_rd;
        end
        du_req = 1'b0; du_stall = 1'b0;
        tick();
        chk("ack_single", 64'(du_ack), 64'(0));
        $display("du %s x%0d data=%h latency=%0d", we ? "write" : "read ", addr,
                 we ? data : du_rdata, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{src1: 5'd1,  dst: 5'd5,  dstv: 64'hA5,                  we: 1'b1, exp_we: 1'b1};
        vecs[1] = '{src1: 5'd2,  dst: 5'd0,  dstv: 64'h1234_5678,           we: 1'b1, exp_we: 1'b0};
        vecs[2] = '{src1: 5'd3,  dst: 5'd6,  dstv: 64'hFFFF_FFFF_FFFF_FFFF, we: 1'b0, exp_we: 1'b0};
        vecs[3] = '{src1: 5'd31, dst: 5'd31, dstv: 64'h8000_0000_0000_0001, we: 1'b1, exp_we: 1'b1};
        vecs[4] = '{src1: 5'd0,  dst: 5'd10, dstv: 64'h55,                  we: 1'b1, exp_we: 1'b1};
        vecs[5] = '{src1: 5'd7,  dst: 5'd0,  dstv: 64'h0,                   we: 1'b0, exp_we: 1'b0};

        rstn = 1'b0; scramble = 1'b1;
        pl_src1 = '0; pl_dst = '0; pl_dstv = '0; pl_we = 1'b1;
        du_stall = 1'b1; du_req = 1'b1; du_we = 1'b1; du_addr = 5'd2; du_wdata = 64'hFEED;
        model_clear();
        tick();
        scramble = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(rf_busy), 64'(1));
        chk("rst_ack", 64'(du_ack), 64'(0));
        chk("rst_rdata", du_rdata, 64'(0));
        chk("rst_dst", 64'(rf_dst), 64'(1));
        tick();
        rstn = 1'b1;
        check_clear();
        // pl_we held high kept the first RUN cycle from admitting the pending debug request.
        pl_we = 1'b0; du_req = 1'b0; du_stall = 1'b0;
        tick();
        chk("run_ack", 64'(du_ack), 64'(0));
        chk("run_busy", 64'(rf_busy), 64'(0));

        for (int v = 0; v < 6; v++) begin
            pl_src1 = vecs[v].src1; pl_dst = vecs[v].dst;
            pl_dstv = vecs[v].dstv; pl_we = vecs[v].we;
            @(negedge clk);
            chk("vec_we", 64'(rf_we), 64'(vecs[v].exp_we));
            chk("vec_dst", 64'(rf_dst), 64'(vecs[v].dst));
            chk("vec_dstv", rf_dstv, vecs[v].dstv);
            chk("vec_src1", 64'(rf_src1), 64'(vecs[v].src1));
            chk("vec_busy", 64'(rf_busy), 64'(0));
            if (vecs[v].exp_we) exp_regs[vecs[v].dst] = vecs[v].dstv;
            tick();
            $display("vector %0d dst=x%0d we=%0b", v, vecs[v].dst, vecs[v].we);
        end
        pl_we = 1'b0;

        du_access(1'b1, 5'd7, 64'h1234, 0);
        du_access(1'b0, 5'd7, 64'h0, 0);
        du_access(1'b0, 5'd5, 64'h0, 10);

        // Pipeline write lands during DU_WR: it goes first, debug write follows, one ack.
        du_req = 1'b1; du_we = 1'b1; du_addr = 5'd9; du_wdata = 64'h9999; du_stall = 1'b1;
        tick();
        pl_we = 1'b1; pl_dst = 5'd3; pl_dstv = 64'h33;
        @(negedge clk);
        chk("col_pl_dst", 64'(rf_dst), 64'(3));
        chk("col_pl_dstv", rf_dstv, 64'h33);
        chk("col_pl_we", 64'(rf_we), 64'(1));
        chk("col_ack0", 64'(du_ack), 64'(0));
        tick();
        pl_we = 1'b0;
        @(negedge clk);
        chk("col_du_dst", 64'(rf_dst), 64'(9));
        chk("col_du_dstv", rf_dstv, 64'h9999);
        chk("col_du_we", 64'(rf_we), 64'(1));
        chk("col_ack1", 64'(du_ack), 64'(0));
        tick();
        chk("col_ack", 64'(du_ack), 64'(1));
        du_req = 1'b0; du_stall = 1'b0;
        tick();
        chk("col_ack_single", 64'(du_ack), 64'(0));
        exp_regs[3] = 64'h33;
        exp_regs[9] = 64'h9999;
        $display("collision write x3 then x9 done");
        du_access(1'b0, 5'd3, 64'h0, 0);
        du_access(1'b0, 5'd9, 64'h0, 1);

        for (int n = 0; n < 60; n++) begin
            int op;
            logic [AR-1:0] a;
            logic [XLEN-1:0] d;
            op = $urandom_range(0, 2);
            a = AR'($urandom_range(0, NREG - 1));
            d = {$urandom, $urandom};
            case (op)
                0: pl_write(AR'($urandom_range(0, NREG - 1)), a, d);
                1: du_access(1'b1, a, d, $urandom_range(0, 3));
                default: du_access(1'b0, a, 64'h0, $urandom_range(0, 3));
            endcase
        end
        for (int r = 0; r < NREG; r++) du_access(1'b0, AR'(r), 64'h0, 0);

        // Reset during a debug read: no ack, clear restarts at x1.
        du_req = 1'b1; du_we = 1'b0; du_addr = 5'd5; du_stall = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_src1", 64'(rf_src1), 64'(5));
        rstn = 1'b0;
        #1;
        chk("t6_rst_dst", 64'(rf_dst), 64'(1));
        chk("t6_rst_busy", 64'(rf_busy), 64'(1));
        chk("t6_rst_ack", 64'(du_ack), 64'(0));
        du_req = 1'b0; du_stall = 1'b0;
        tick();
        chk("t6_ack_hold", 64'(du_ack), 64'(0));
        chk("t6_rdata_rst", du_rdata, 64'(0));
        rstn = 1'b1;
        model_clear();
        check_clear();
        tick();
        pl_write(5'd0, 5'd4, 64'hDEAD);
        du_access(1'b0, 5'd4, 64'h0, 0);
        du_access(1'b0, 5'd0, 64'h0, 0);
        du_access(1'b0, 5'd17, 64'h0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
